// File: rtl/alarm_controller.sv
// alarm_controller: routes the shared HOURS/MINS buttons to the time or alarm counter, gates
//    timekeeping while the time is being set, and runs the alarm ring/snooze state machine.
// Latency: all outputs are registered; button routing and the FSM respond one cycle after their inputs.
// Backpressure: none. Pulses that arrive while neither set mode is active are dropped.
// Ports:
//    clk, reset                      - clock, synchronous active-high reset
//    TIME_SET, ALARM_SET, ALARM_EN   - front-panel level inputs
//    HOURS, MINS, STOP_ALARM, SNOOZE - front-panel one-cycle pulses
//    SEC_TICK                        - one-cycle pulse once per second
//    CUR_*, ALM_*                    - running time and stored alarm time
//    TIME_*_INC, ALARM_*_INC         - routed adjust pulses to the two counters
//    TIME_RUN, DISPLAY_SEL           - timekeeping enable, display source select
//    ALARM_RING, SNOOZE_CNT, STATE   - buzzer drive, snoozes used, FSM state
module alarm_controller #(
   parameter int unsigned RING_SECS   = 60,
   parameter int unsigned SNOOZE_SECS = 120,
   parameter int unsigned MAX_SNOOZE  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       TIME_SET,
   input  logic       ALARM_SET,
   input  logic       HOURS,
   input  logic       MINS,
   input  logic       ALARM_EN,
   input  logic       STOP_ALARM,
   input  logic       SNOOZE,
   input  logic       SEC_TICK,
   input  logic [3:0] CUR_HOURS,
   input  logic [5:0] CUR_MINUTES,
   input  logic       CUR_AM_PM,
   input  logic [3:0] ALM_HOURS,
   input  logic [5:0] ALM_MINUTES,
   input  logic       ALM_AM_PM,
   output logic       TIME_HOURS_INC,
   output logic       TIME_MINS_INC,
   output logic       ALARM_HOURS_INC,
   output logic       ALARM_MINS_INC,
   output logic       TIME_RUN,
   output logic       DISPLAY_SEL,
   output logic       ALARM_RING,
   output logic [1:0] SNOOZE_CNT,
   output logic [1:0] STATE
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ARMED    = 2'd1,
      S_RINGING  = 2'd2,
      S_SNOOZING = 2'd3
   } state_t;

   localparam logic [7:0] RING_T   = 8'(RING_SECS);
   localparam logic [7:0] SNOOZE_T = 8'(SNOOZE_SECS);
   localparam logic [1:0] MAX_SNZ  = 2'(MAX_SNOOZE);

   state_t     state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [1:0] snz_q, snz_d;
   logic       match_q;
   logic       ring_q;
   logic       t_hours_q, t_mins_q, a_hours_q, a_mins_q;
   logic       run_q, dsel_q;

   logic setmode_t, setmode_a, match, trigger, expire, counting;

   // TIME_SET has priority over ALARM_SET when both are held.
   assign setmode_t = TIME_SET;
   assign setmode_a = ALARM_SET & ~TIME_SET;

   assign match    = ({CUR_AM_PM, CUR_HOURS, CUR_MINUTES} == {ALM_AM_PM, ALM_HOURS, ALM_MINUTES});
   // Only the rising edge of a match rings, so silencing the alarm inside the
   // matching minute never restarts it. Set modes suppress the edge entirely.
   assign trigger  = match & ~match_q & ~TIME_SET & ~ALARM_SET;
   assign expire   = SEC_TICK & (timer_q == 8'd1);
   assign counting = (state_q == S_RINGING) || (state_q == S_SNOOZING);

   always_comb begin
      state_d = state_q;
      snz_d   = snz_q;
      timer_d = timer_q;
      // Reload assignments below override this decrement, so a tick landing
      // on a reload cycle never eats into the fresh interval.
      if (counting && SEC_TICK) begin
         timer_d = timer_q - 8'd1;
      end

      if (!ALARM_EN) begin
         state_d = S_IDLE;
         timer_d = 8'd0;
         snz_d   = 2'd0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_ARMED;
            end
            S_ARMED: begin
               if (trigger) begin
                  state_d = S_RINGING;
                  timer_d = RING_T;
                  snz_d   = 2'd0;
               end
            end
            S_RINGING: begin
               if (TIME_SET || ALARM_SET || STOP_ALARM) begin
                  state_d = S_ARMED;
                  snz_d   = 2'd0;
               end else if (SNOOZE && (snz_q < MAX_SNZ)) begin
                  state_d = S_SNOOZING;
                  timer_d = SNOOZE_T;
                  snz_d   = snz_q + 2'd1;
               end else if (expire) begin
                  // A snooze refused at the limit falls through to here.
                  state_d = S_ARMED;
                  snz_d   = 2'd0;
               end
            end
            S_SNOOZING: begin
               if (TIME_SET || ALARM_SET || STOP_ALARM) begin
                  state_d = S_ARMED;
                  snz_d   = 2'd0;
               end else if (expire) begin
                  state_d = S_RINGING;
                  timer_d = RING_T;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         timer_q   <= 8'd0;
         snz_q     <= 2'd0;
         // Both counters reset to 00:00 AM; starting "already matched" keeps
         // that coincidence from ringing.
         match_q   <= 1'b1;
         ring_q    <= 1'b0;
         t_hours_q <= 1'b0;
         t_mins_q  <= 1'b0;
         a_hours_q <= 1'b0;
         a_mins_q  <= 1'b0;
         run_q     <= 1'b1;
         dsel_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         snz_q     <= snz_d;
         match_q   <= match;
         ring_q    <= (state_d == S_RINGING);
         t_hours_q <= HOURS & setmode_t;
         t_mins_q  <= MINS & setmode_t;
         a_hours_q <= HOURS & setmode_a;
         a_mins_q  <= MINS & setmode_a;
         run_q     <= ~TIME_SET;
         dsel_q    <= setmode_a;
      end
   end

   assign TIME_HOURS_INC  = t_hours_q;
   assign TIME_MINS_INC   = t_mins_q;
   assign ALARM_HOURS_INC = a_hours_q;
   assign ALARM_MINS_INC  = a_mins_q;
   assign TIME_RUN        = run_q;
   assign DISPLAY_SEL     = dsel_q;
   assign ALARM_RING      = ring_q;
   assign SNOOZE_CNT      = snz_q;
   assign STATE           = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
module tb_alarm_controller;

   localparam int RS = 5;
   localparam int SS = 3;
   localparam int MS = 2;

   logic       clk = 1'b0;
   logic       reset, TIME_SET, ALARM_SET, HOURS, MINS, ALARM_EN, STOP_ALARM, SNOOZE, SEC_TICK;
   logic [3:0] CUR_HOURS, ALM_HOURS;
   logic [5:0] CUR_MINUTES, ALM_MINUTES;
   logic       CUR_AM_PM, ALM_AM_PM;
   logic       TIME_HOURS_INC, TIME_MINS_INC, ALARM_HOURS_INC, ALARM_MINS_INC;
   logic       TIME_RUN, DISPLAY_SEL, ALARM_RING;
   logic [1:0] SNOOZE_CNT, STATE;

   always #5 clk = ~clk;

   alarm_controller #(.RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MS)) dut (
      .clk(clk), .reset(reset), .TIME_SET(TIME_SET), .ALARM_SET(ALARM_SET),
      .HOURS(HOURS), .MINS(MINS), .ALARM_EN(ALARM_EN), .STOP_ALARM(STOP_ALARM),
      .SNOOZE(SNOOZE), .SEC_TICK(SEC_TICK),
      .CUR_HOURS(CUR_HOURS), .CUR_MINUTES(CUR_MINUTES), .CUR_AM_PM(CUR_AM_PM),
      .ALM_HOURS(ALM_HOURS), .ALM_MINUTES(ALM_MINUTES), .ALM_AM_PM(ALM_AM_PM),
      .TIME_HOURS_INC(TIME_HOURS_INC), .TIME_MINS_INC(TIME_MINS_INC),
      .ALARM_HOURS_INC(ALARM_HOURS_INC), .ALARM_MINS_INC(ALARM_MINS_INC),
      .TIME_RUN(TIME_RUN), .DISPLAY_SEL(DISPLAY_SEL), .ALARM_RING(ALARM_RING),
      .SNOOZE_CNT(SNOOZE_CNT), .STATE(STATE)
   );

   // Expected output vector: {TH_INC, TM_INC, AH_INC, AM_INC, TIME_RUN, DISPLAY_SEL, RING, SNOOZE_CNT, STATE}
   logic [10:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int n_cyc    = 0;

   // Reference model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing; secs_left is the
   // remaining seconds of the current ring/snooze interval; times compared as minute-of-day.
   int mode, secs_left, snoozes;
   bit prev_match;

   task automatic step();
      logic [10:0] e;
      int  cur_t, alm_t;
      bit  match, trig, expire, setm;
      if (reset) begin
         mode = 0; secs_left = 0; snoozes = 0; prev_match = 1'b1;
         e = 11'b0000_1_0_0_00_00;
      end else begin
         cur_t = int'(CUR_AM_PM) * 720 + int'(CUR_HOURS) * 60 + int'(CUR_MINUTES);
         alm_t = int'(ALM_AM_PM) * 720 + int'(ALM_HOURS) * 60 + int'(ALM_MINUTES);
         match = (cur_t == alm_t);
         trig  = match && !prev_match && !TIME_SET && !ALARM_SET;
         prev_match = match;
         expire = SEC_TICK && (secs_left == 1);
         setm   = TIME_SET || ALARM_SET;
         if ((mode == 2 || mode == 3) && SEC_TICK) secs_left = secs_left - 1;
         if (!ALARM_EN) begin
            mode = 0; secs_left = 0; snoozes = 0;
         end else if (mode == 0) begin
            mode = 1;
         end else if (mode == 1) begin
            if (trig) begin mode = 2; secs_left = RS; snoozes = 0; end
         end else if (setm || STOP_ALARM) begin
            mode = 1; snoozes = 0;
         end else if (mode == 2) begin
            if (SNOOZE && snoozes < MS) begin mode = 3; secs_left = SS; snoozes = snoozes + 1; end
            else if (expire) begin mode = 1; snoozes = 0; end
         end else if (expire) begin
            mode = 2; secs_left = RS;
         end
         e = {HOURS && TIME_SET, MINS && TIME_SET,
              HOURS && ALARM_SET && !TIME_SET, MINS && ALARM_SET && !TIME_SET,
              !TIME_SET, ALARM_SET && !TIME_SET, mode == 2, 2'(snoozes), 2'(mode)};
      end
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: every clock the DUT presents a fresh output vector; compare it with the oldest expectation.
   logic [10:0] mon_exp, mon_got;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_got = {TIME_HOURS_INC, TIME_MINS_INC, ALARM_HOURS_INC, ALARM_MINS_INC,
                    TIME_RUN, DISPLAY_SEL, ALARM_RING, SNOOZE_CNT, STATE};
         n_cyc++;
         n_checks++;
         if (mon_got === mon_exp) n_pass++;
         else $display("FAIL outputs cycle=%0d got=%b required=%b (TH TM AH AM RUN DSEL RING SNZ ST)",
                       n_cyc, mon_got, mon_exp);
      end
   end

   task automatic clear_pulses();
      HOURS = 0; MINS = 0; STOP_ALARM = 0; SNOOZE = 0; SEC_TICK = 0;
   endtask

   task automatic rand_alarm();
      ALM_HOURS = 4'($urandom_range(11, 0));
      ALM_MINUTES = 6'($urandom_range(59, 0));
      ALM_AM_PM = 1'($urandom_range(1, 0));
   endtask

   task automatic cur_off();
      CUR_HOURS = ALM_HOURS; CUR_AM_PM = ALM_AM_PM;
      CUR_MINUTES = (ALM_MINUTES == 6'd59) ? 6'd0 : ALM_MINUTES + 6'd1;
   endtask

   task automatic cur_on();
      CUR_HOURS = ALM_HOURS; CUR_MINUTES = ALM_MINUTES; CUR_AM_PM = ALM_AM_PM;
   endtask

   // Steer the design into RINGING (tracked via the model), bounded.
   task automatic get_ringing();
      int n;
      clear_pulses(); TIME_SET = 0; ALARM_SET = 0; ALARM_EN = 1;
      cur_off(); step(); step();
      cur_on();
      n = 0;
      while (mode != 2 && n < 20) begin step(); n++; end
      n_checks++;
      if (mode == 2) n_pass++;
      else $display("FAIL reach_ringing got_mode=%0d required=2", mode);
   endtask

   initial begin
      reset = 1; TIME_SET = 0; ALARM_SET = 0; ALARM_EN = 0; clear_pulses();
      CUR_HOURS = 0; CUR_MINUTES = 0; CUR_AM_PM = 0;
      ALM_HOURS = 0; ALM_MINUTES = 0; ALM_AM_PM = 0;
      step(); step();
      // Both counters at 00:00 AM right after reset must not ring.
      reset = 0; ALARM_EN = 1;
      repeat (8) step();

      // Routing, including TIME_SET beating ALARM_SET and dropped pulses.
      TIME_SET = 1; HOURS = 1; step(); HOURS = 0; step();
      ALARM_SET = 1; MINS = 1; step(); MINS = 0; step();
      TIME_SET = 0; HOURS = 1; step(); HOURS = 0; step();
      ALARM_SET = 0; MINS = 1; HOURS = 1; step(); clear_pulses(); step();

      // Ring, then auto-stop with CUR held on the alarm minute.
      ALM_HOURS = 4'd6; ALM_MINUTES = 6'd30; ALM_AM_PM = 0;
      get_ringing();
      repeat (20) begin SEC_TICK = ~SEC_TICK; step(); end
      SEC_TICK = 0; repeat (4) step();

      // Snooze up to the limit, then a refused snooze.
      get_ringing();
      repeat (2) begin
         SNOOZE = 1; step(); SNOOZE = 0;
         repeat (SS) begin SEC_TICK = 1; step(); SEC_TICK = 0; step(); end
      end
      SNOOZE = 1; step(); SNOOZE = 0; step();
      // Tick on the snooze-reload cycle is not applied.
      STOP_ALARM = 1; step(); STOP_ALARM = 0;
      get_ringing();
      SNOOZE = 1; SEC_TICK = 1; step(); SNOOZE = 0;
      repeat (6) step();
      SEC_TICK = 0;

      // STOP beats SNOOZE; ALARM_EN drop while snoozing.
      get_ringing();
      STOP_ALARM = 1; SNOOZE = 1; step(); clear_pulses(); step();
      get_ringing();
      SNOOZE = 1; step(); SNOOZE = 0; step();
      ALARM_EN = 0; step(); ALARM_EN = 1; step();

      // Reset mid-ring.
      get_ringing();
      reset = 1; step(); reset = 0; repeat (3) step();

      // ALARM_SET cancels ringing; a match edge under ALARM_SET never rings.
      get_ringing();
      ALARM_SET = 1; step(); step();
      cur_off(); step(); cur_on(); repeat (3) step();
      ALARM_SET = 0; repeat (3) step();

      // Randomized phase.
      rand_alarm(); cur_off();
      for (int i = 0; i < 6000; i++) begin
         reset      = ($urandom % 700 == 0);
         HOURS      = ($urandom % 6 == 0);
         MINS       = ($urandom % 6 == 0);
         SEC_TICK   = ($urandom % 3 == 0);
         STOP_ALARM = ($urandom % 40 == 0);
         SNOOZE     = ($urandom % 12 == 0);
         if (TIME_SET) TIME_SET = ($urandom % 8 != 0);
         else          TIME_SET = ($urandom % 90 == 0);
         if (ALARM_SET) ALARM_SET = ($urandom % 8 != 0);
         else           ALARM_SET = ($urandom % 80 == 0);
         if (ALARM_EN) ALARM_EN = ($urandom % 300 != 0);
         else          ALARM_EN = ($urandom % 10 == 0);
         if ($urandom % 150 == 0) rand_alarm();
         if ($urandom % 6 == 0) begin
            case ($urandom % 5)
               0, 1: cur_on();
               2: begin cur_on(); CUR_AM_PM = ~ALM_AM_PM; end
               3: begin cur_on(); CUR_HOURS = (ALM_HOURS == 4'd11) ? 4'd0 : ALM_HOURS + 4'd1; end
               default: begin
                  CUR_HOURS = 4'($urandom_range(11, 0));
                  CUR_MINUTES = 6'($urandom_range(59, 0));
                  CUR_AM_PM = 1'($urandom_range(1, 0));
               end
            endcase
         end
         step();
      end

      reset = 0; clear_pulses();
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Sequencing and arbitration block for the clock/alarm circuit.
- Routes the shared HOURS/MINS adjust buttons to either the timekeeping counter or the alarm counter, and gates timekeeping during time set.
- Compares running time against stored alarm time and drives the alarm ring/snooze state machine.
- Sits between the front-panel inputs, the two time counters and the buzzer/display.

Parameters:
RING_SECS, 60, seconds ALARM_RING stays high before auto-stop (1..255)
SNOOZE_SECS, 120, seconds of silence per snooze (1..255)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0..3)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
TIME_SET  in  1  level; buttons adjust time counter, time stops
ALARM_SET  in  1  level; buttons adjust alarm counter
HOURS  in  1  one-cycle hour-adjust pulse
MINS  in  1  one-cycle minute-adjust pulse
ALARM_EN  in  1  level; alarm armed when 1
STOP_ALARM  in  1  one-cycle pulse
SNOOZE  in  1  one-cycle pulse
SEC_TICK  in  1  one-cycle pulse, once per second
CUR_HOURS  in  4  running time hours 0..11
CUR_MINUTES  in  6  running time minutes 0..59
CUR_AM_PM  in  1  running time AM(0)/PM(1)
ALM_HOURS  in  4  alarm hours 0..11
ALM_MINUTES  in  6  alarm minutes 0..59
ALM_AM_PM  in  1  alarm AM/PM
TIME_HOURS_INC  out  1  hour pulse to time counter
TIME_MINS_INC  out  1  minute pulse to time counter
ALARM_HOURS_INC  out  1  hour pulse to alarm counter
ALARM_MINS_INC  out  1  minute pulse to alarm counter
TIME_RUN  out  1  timekeeping enable
DISPLAY_SEL  out  1  0 = show time, 1 = show alarm
ALARM_RING  out  1  buzzer drive
SNOOZE_CNT  out  2  snoozes used in current event
STATE  out  2  FSM state: 0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZING

Behaviour:
- Reset (sync, high) values:
  - All outputs 0 except TIME_RUN=1.
  - STATE=IDLE, timer=0, SNOOZE_CNT=0.
  - match_q=1, so the reset-equal 00:00 AM of both counters never rings.
- Button routing (all registered, 1-cycle latency):
  - setmode_t = TIME_SET.
  - setmode_a = ALARM_SET & !TIME_SET; TIME_SET wins when both are high.
  - TIME_*_INC = button & setmode_t.
  - ALARM_*_INC = button & setmode_a.
  - With neither mode active, button pulses are dropped.
  - TIME_RUN = !TIME_SET.
  - DISPLAY_SEL = setmode_a.
- Match detection:
  - match = full 11-bit equality of CUR and ALM.
  - match_q registers match every cycle.
  - trigger = match & !match_q & !TIME_SET & !ALARM_SET, i.e. rising edge only. The alarm therefore rings once per matching minute, and stopping it inside that minute never retriggers.
- Timer:
  - 8-bit down-counter, decremented on SEC_TICK while in RINGING/SNOOZING.
  - expire = SEC_TICK & timer==1.
- FSM transitions (priority high to low, evaluated each cycle):
  - any state: ALARM_EN=0 -> IDLE, timer=0, SNOOZE_CNT=0.
  - IDLE: ALARM_EN=1 -> ARMED.
  - RINGING/SNOOZING: TIME_SET|ALARM_SET -> ARMED, SNOOZE_CNT=0.
  - ARMED: trigger -> RINGING, timer=RING_SECS, SNOOZE_CNT=0.
  - RINGING:
    - STOP_ALARM -> ARMED, SNOOZE_CNT=0.
    - SNOOZE with SNOOZE_CNT<MAX_SNOOZE -> SNOOZING, timer=SNOOZE_SECS, SNOOZE_CNT+1.
    - SNOOZE with SNOOZE_CNT==MAX_SNOOZE is ignored.
    - expire -> ARMED, SNOOZE_CNT=0.
  - SNOOZING:
    - STOP_ALARM -> ARMED, SNOOZE_CNT=0.
    - expire -> RINGING, timer=RING_SECS.
- Output timing:
  - ALARM_RING and STATE are registered from the next-state.
  - ALARM_RING=1 exactly while STATE==RINGING.
  - ALARM_RING rises the cycle after the trigger edge is sampled.
- Simultaneous events:
  - STOP_ALARM beats SNOOZE.
  - STOP_ALARM/SNOOZE beat an expire arriving in the same cycle.
  - A trigger in a non-ARMED state is ignored.
- SEC_TICK during a reload cycle is not applied, so the new timer value is loaded intact.
- Reset mid-ring: ALARM_RING drops the cycle after reset is sampled, and the FSM returns to IDLE.

Test Plan:
1. Routing: TIME_SET=1, pulse HOURS -> TIME_HOURS_INC=1 one cycle later, ALARM_HOURS_INC=0, TIME_RUN=0. TIME_SET=ALARM_SET=1, pulse MINS -> only TIME_MINS_INC. Both low -> no INC outputs.
2. Trigger and auto-stop: ALARM_EN=1, ALM=06:30 AM; step CUR to 06:30 AM -> STATE=2, ALARM_RING=1 next cycle. With RING_SECS=5, after 5 SEC_TICKs -> STATE=1, ALARM_RING=0, no re-ring while CUR stays 06:30.
3. Snooze limit: MAX_SNOOZE=2, SNOOZE_SECS=3. SNOOZE -> STATE=3, SNOOZE_CNT=1; 3 ticks -> STATE=2. Repeat -> SNOOZE_CNT=2. Third SNOOZE -> ignored, ALARM_RING stays 1.
4. Priority: STOP_ALARM and SNOOZE in the same cycle while RINGING -> STATE=1, SNOOZE_CNT=0. ALARM_EN dropped in SNOOZING -> STATE=0.
5. Reset: after reset, CUR=ALM=00:00 AM with ALARM_EN=1 -> no ring. Assert reset mid-RINGING -> ALARM_RING=0, STATE=0, TIME_RUN=1.
6. Set-mode cancel: RINGING, raise ALARM_SET -> STATE=1, DISPLAY_SEL=1. Match edge occurring while ALARM_SET=1 -> no ring.
